// File: rtl/mc_control_unit.sv
//==============================================================================
// Module      : mc_control_unit
// Description : Multicycle control unit for the RV32I subset
//               (lw, sw, R-type ALU, I-type ALU, beq, jal). A Moore FSM steps
//               the datapath one phase per cycle. Its outputs are decoded
//               combinationally from the current state. PCWrite is the only
//               Mealy term, because of the beq/zero dependency.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               op/funct3/funct7b5  - instruction fields held by the IR
//               zero                - ALU zero flag (used in BEQ only)
//               PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
//               ALUSrcB, ALUControl, ImmSrc, RegWrite - datapath controls
//               illegal_op          - one-cycle pulse in DECODE on bad opcode
//               state               - current FSM state (debug)
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module mc_control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam logic [6:0] c_OP_LW     = 7'b0000011;
    localparam logic [6:0] c_OP_SW     = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] c_OP_BEQ    = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    state_t     w_out_state;
    logic       w_illegal;
    logic       w_pc_update;
    logic       w_branch;
    logic       w_ir_write;
    logic       w_mem_write;
    logic       w_reg_write;
    logic [1:0] w_alu_op;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = S_FETCH;
        w_illegal    = 1'b0;
        case (r_state)
            S_FETCH:    w_next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    c_OP_LW,
                    c_OP_SW:    w_next_state = S_MEMADR;
                    c_OP_RTYPE: w_next_state = S_EXECR;
                    c_OP_ITYPE: w_next_state = S_EXECI;
                    c_OP_BEQ:   w_next_state = S_BEQ;
                    c_OP_JAL:   w_next_state = S_JAL;
                    default: begin
                        w_next_state = S_FETCH;
                        w_illegal    = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   w_next_state = (op == c_OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next_state = S_MEMWB;
            S_MEMWB:    w_next_state = S_FETCH;
            S_MEMWRITE: w_next_state = S_FETCH;
            S_EXECR:    w_next_state = S_ALUWB;
            S_EXECI:    w_next_state = S_ALUWB;
            S_ALUWB:    w_next_state = S_FETCH;
            S_BEQ:      w_next_state = S_FETCH;
            S_JAL:      w_next_state = S_ALUWB;
            default:    w_next_state = S_FETCH;   // unreachable codes recover
        endcase
    end

    // During reset the datapath selects show FETCH values. The write enables
    // are masked separately below, so an aborted instruction never commits.
    assign w_out_state = reset ? S_FETCH : r_state;

    // Moore output decode
    always_comb begin
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        w_alu_op    = 2'b00;
        AdrSrc      = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        case (w_out_state)
            S_FETCH: begin
                w_ir_write  = 1'b1;
                w_pc_update = 1'b1;
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                w_reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA  = 2'b10;
                w_alu_op = 2'b10;
            end
            S_EXECI: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b01;
                w_alu_op = 2'b10;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA  = 2'b10;
                w_alu_op = 2'b01;
                w_branch = 1'b1;
            end
            S_JAL: begin
                ALUSrcA     = 2'b01;
                ALUSrcB     = 2'b10;
                w_pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    assign PCWrite    = ~reset & (w_pc_update | (w_branch & zero));
    assign IRWrite    = ~reset & w_ir_write;
    assign MemWrite   = ~reset & w_mem_write;
    assign RegWrite   = ~reset & w_reg_write;
    assign illegal_op = ~reset & w_illegal;
    assign state      = r_state;

    // ALU decoder. Subtraction applies only to R-type (op[5]=1) with
    // funct7b5 set. addi carries immediate bits in funct7b5 and must stay add.
    always_comb begin
        ALUControl = 3'b000;
        case (w_alu_op)
            2'b00: ALUControl = 3'b000;
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    // Immediate format decoder
    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            c_OP_SW:  ImmSrc = 2'b01;
            c_OP_BEQ: ImmSrc = 2'b10;
            c_OP_JAL: ImmSrc = 2'b11;
            default:  ImmSrc = 2'b00;
        endcase
    end

endmodule

`default_nettype wire

// File: doc/mc_control_unit.md
# mc_control_unit

Multicycle control unit for the RISC-V core. It decodes the instruction-register fields and drives every datapath select and write enable one step per cycle. It is the producer of the 3-bit `ALUControl` code that the ALU consumes, so its encoding must match the ALU's add, subtract, and, or and slt functions. Supported instructions: lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq, jal.

## Interface
- No parameters; all widths are fixed by the RV32I encoding.

- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high
- `op`  in  7  instr[6:0], held stable by the IR from DECODE until the next FETCH
- `funct3`  in  3  instr[14:12]
- `funct7b5`  in  1  instr[30]
- `zero`  in  1  ALU zero flag
- `PCWrite`  out  1  PC load enable
- `AdrSrc`  out  1  memory address: 0 = PC, 1 = ALU result register
- `MemWrite`  out  1  data memory write
- `IRWrite`  out  1  IR and OldPC load
- `ResultSrc`  out  2  00 = ALUOut, 01 = Data, 10 = ALU result
- `ALUSrcA`  out  2  00 = PC, 01 = OldPC, 10 = rs1 register
- `ALUSrcB`  out  2  00 = rs2 register, 01 = immediate, 10 = constant 4
- `ALUControl`  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- `ImmSrc`  out  2  00 I, 01 S, 10 B, 11 J
- `RegWrite`  out  1  register file write
- `illegal_op`  out  1  one-cycle pulse in DECODE when the opcode is unsupported
- `state`  out  4  current state, for debug

## Operation
**State register**
- 4-bit `state`, reset to FETCH.
- Encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10.
- Codes 11–15 are unreachable; if entered, the next state is FETCH.

**Transitions**
- FETCH → DECODE.
- DECODE, by `op`:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BEQ
  - 1101111 → JAL
  - any other opcode → FETCH, with `illegal_op`=1 for that cycle
- MEMADR → MEMREAD if `op`=0000011, else MEMWRITE.
- MEMREAD → MEMWB → FETCH.
- MEMWRITE → FETCH.
- EXECR and EXECI → ALUWB → FETCH.
- JAL → ALUWB.
- BEQ → FETCH.

**Moore outputs.** Any output not listed for a state is 0.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (computes the branch target).
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
- MEMREAD: ResultSrc=00, AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: ResultSrc=00, RegWrite=1.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
- `PCWrite` = PCUpdate | (Branch & `zero`). This is the only Mealy term.

**ALU decoder** (combinational)
- ALUOp 00 → 000 (add).
- ALUOp 01 → 001 (sub).
- ALUOp 10, by `funct3`:
  - 000 → 001 if {`op[5]`, `funct7b5`}=11, else 000
  - 010 → 101
  - 110 → 011
  - 111 → 010
  - any other → 000

**Immediate decoder** (combinational, from `op`)
- 0000011 and 0010011 → 00.
- 0100011 → 01.
- 1100011 → 10.
- 1101111 → 11.
- All other opcodes, including R-type → 00.

## Timing
**Reset**
- `reset` is sampled on the rising edge of `clk`; the next state is FETCH.
- While `reset`=1, `PCWrite`, `IRWrite`, `MemWrite`, `RegWrite` and `illegal_op` are forced to 0.
- All other outputs show FETCH values during reset: ALUSrcB=10, ResultSrc=10, ALUControl=000.
- Reset asserted mid-instruction aborts it. No memory or register write occurs in the reset cycle, even if `state` was MEMWRITE or ALUWB.
- The first edge after `reset` falls performs the FETCH.

**Cycles per instruction**
- lw 5; sw 4; R-type 4; I-type 4; jal 4; beq 3; illegal opcode 2.

**Pulse widths**
- Every write enable is high for exactly one cycle per instruction.
- `PCWrite` goes high once per instruction in FETCH, plus once in JAL, plus once in BEQ when `zero`=1.

**Input timing**
- `zero` is used only in BEQ and must be valid in that cycle before the clock edge.
- `op`, `funct3` and `funct7b5` are ignored in FETCH.

## Test plan
- **Reset mid-instruction:** assert `reset` for 1 cycle while in MEMWRITE → `MemWrite`=0 in that cycle; `state`=0 next cycle; during reset `ALUSrcB`=10 and all write enables 0.
- **lw:** `op`=0000011 → `state` sequence 0,1,2,3,4,0; `RegWrite`=1 only in state 4 with ResultSrc=01; `ImmSrc`=00; `ALUControl`=000 in state 2.
- **sw:** `op`=0100011 → `state` sequence 0,1,2,5,0; `MemWrite`=1 only in state 5 with AdrSrc=1; `ImmSrc`=01.
- **R-type:** `op`=0110011 with `funct3`/`funct7b5` = 000/1, 000/0, 010/0, 110/0, 111/0 → `ALUControl` in EXECR = 001, 000, 101, 011, 010.
- **addi with funct7b5=1:** `op`=0010011, `funct3`=000, `funct7b5`=1 → `ALUControl`=000 (not sub).
- **beq:** `op`=1100011 with `zero`=1 → `PCWrite`=1 in BEQ with `ALUControl`=001; with `zero`=0 → `PCWrite`=0; both cases return to FETCH after 3 cycles.
- **jal:** `op`=1101111 → sequence 0,1,10,8,0 with `PCWrite`=1 in JAL and `RegWrite`=1 in ALUWB.
- **Illegal opcode:** `op`=0110111 → `illegal_op`=1 for exactly one cycle in DECODE; next `state`=0; no write enable asserted.
